// File: rtl/gpu_operand_collector.sv
// Operand collector: gathers up to three source operands through one RF read port.
// Optional macro GPU_OPC_SKIP_R0_EN: r0 sources read as zero with no read cycle.
module gpu_operand_collector #(
    parameter int REG_NUM    = 32,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 8,
    localparam int AW        = $clog2(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic [1:0]            in_nsrc,
    input  logic [AW-1:0]         in_src0,
    input  logic [AW-1:0]         in_src1,
    input  logic [AW-1:0]         in_src2,
    input  logic [AW-1:0]         in_dst,
    output logic [AW-1:0]         rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [AW-1:0]         out_dst,
    output logic [DATA_WIDTH-1:0] out_op0,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    idx;
    logic [2:0]    pend;
    logic [2:0]    pend_left;
    logic [2:0]    need;
    logic [AW-1:0] src0_q;
    logic [AW-1:0] src1_q;
    logic [AW-1:0] src2_q;
    logic          accept;

    function automatic logic [1:0] first_set(input logic [2:0] m);
        logic [1:0] r;
        r = 2'd0;
        if (m[2]) r = 2'd2;
        if (m[1]) r = 2'd1;
        if (m[0]) r = 2'd0;
        return r;
    endfunction

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign pend_left = pend & ~(3'b001 << idx);

    // Bit i set: operand i needs a read cycle.
    always_comb begin
        need[0] = (in_nsrc != 2'd0);
        need[1] = (in_nsrc >= 2'd2);
        need[2] = (in_nsrc == 2'd3);
`ifdef GPU_OPC_SKIP_R0_EN
        need[0] = need[0] && (in_src0 != '0);
        need[1] = need[1] && (in_src1 != '0);
        need[2] = need[2] && (in_src2 != '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            state_nx = (need == '0) ? DONE : READ;
        end else begin
            unique case (state)
                IDLE:    state_nx = IDLE;
                READ:    if (pend_left == '0) state_nx = DONE;
                DONE:    if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        rf_read_addr = '0;
        if (state == READ) begin
            unique case (idx)
                2'd0:    rf_read_addr = src0_q;
                2'd1:    rf_read_addr = src1_q;
                2'd2:    rf_read_addr = src2_q;
                default: rf_read_addr = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_tag <= '0;
            out_dst <= '0;
            out_op0 <= '0;
            out_op1 <= '0;
            out_op2 <= '0;
            src0_q  <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            pend    <= '0;
            idx     <= '0;
        end else if (accept) begin
            out_tag <= in_tag;
            out_dst <= in_dst;
            out_op0 <= '0;
            out_op1 <= '0;
            out_op2 <= '0;
            src0_q  <= in_src0;
            src1_q  <= in_src1;
            src2_q  <= in_src2;
            pend    <= need;
            idx     <= first_set(need);
        end else if (state == READ) begin
            case (idx)
                2'd0:    out_op0 <= rf_read_data;
                2'd1:    out_op1 <= rf_read_data;
                2'd2:    out_op2 <= rf_read_data;
                default: ;
            endcase
            pend <= pend_left;
            idx  <= first_set(pend_left);
        end
    end

endmodule

// File: tb/tb_gpu_operand_collector.sv
// Bench for gpu_operand_collector: directed literal cases plus random traffic
// compared every cycle against a queue-based transaction model.
module tb_gpu_operand_collector;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_tag;
    logic [1:0]    in_nsrc;
    logic [AW-1:0] in_src0;
    logic [AW-1:0] in_src1;
    logic [AW-1:0] in_src2;
    logic [AW-1:0] in_dst;
    logic [AW-1:0] rf_read_addr;
    logic [DW-1:0] rf_read_data;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_tag;
    logic [AW-1:0] out_dst;
    logic [DW-1:0] out_op0;
    logic [DW-1:0] out_op1;
    logic [DW-1:0] out_op2;
    logic          busy;

    logic [DW-1:0] rf [32];

    always #5 clk = ~clk;

    assign rf_read_data = rf[rf_read_addr];

    gpu_operand_collector #(
        .REG_NUM(32), .DATA_WIDTH(DW), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_tag(in_tag), .in_nsrc(in_nsrc),
        .in_src0(in_src0), .in_src1(in_src1), .in_src2(in_src2),
        .in_dst(in_dst),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_dst(out_dst),
        .out_op0(out_op0), .out_op1(out_op1), .out_op2(out_op2),
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model: an instruction in flight plus a queue of reads left.
    bit            m_busy;
    logic [TW-1:0] m_tag;
    logic [AW-1:0] m_dst;
    logic [DW-1:0] m_op [3];
    logic [AW-1:0] m_sv [3];
    int            rq_i [$];
    int            rq_a [$];
    int            m_emit = 0;
    int            d_emit = 0;
    bit            chk_en = 0;
    bit            m_v;
    bit            m_rdy;
    bit            e_v;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0;
            rq_i.delete();
            rq_a.delete();
            m_tag = '0;
            m_dst = '0;
            for (int k = 0; k < 3; k++) m_op[k] = '0;
        end else begin
            if (out_valid && out_ready) d_emit++;
            m_v   = m_busy && (rq_i.size() == 0);
            m_rdy = !m_busy || (m_v && out_ready);
            if (m_v && out_ready) begin
                m_busy = 0;
                m_emit++;
            end
            if (m_busy && rq_i.size() != 0) begin
                m_op[rq_i[0]] = rf[rq_a[0]];
                void'(rq_i.pop_front());
                void'(rq_a.pop_front());
            end
            if (in_valid && m_rdy) begin
                m_busy  = 1;
                m_tag   = in_tag;
                m_dst   = in_dst;
                m_sv[0] = in_src0;
                m_sv[1] = in_src1;
                m_sv[2] = in_src2;
                for (int k = 0; k < 3; k++) m_op[k] = '0;
                for (int k = 0; k < int'(in_nsrc); k++) begin
`ifdef GPU_OPC_SKIP_R0_EN
                    if (m_sv[k] == '0) continue;
`endif
                    rq_i.push_back(k);
                    rq_a.push_back(int'(m_sv[k]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            e_v = m_busy && (rq_i.size() == 0);
            chk("in_ready", 64'(in_ready), 64'(!m_busy || (e_v && out_ready)));
            chk("out_valid", 64'(out_valid), 64'(e_v));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("rf_addr", 64'(rf_read_addr),
                (m_busy && rq_a.size() > 0) ? 64'(rq_a[0]) : 64'd0);
            if (e_v) begin
                chk("out_tag", 64'(out_tag), 64'(m_tag));
                chk("out_dst", 64'(out_dst), 64'(m_dst));
                chk("out_op0", out_op0, m_op[0]);
                chk("out_op1", out_op1, m_op[1]);
                chk("out_op2", out_op2, m_op[2]);
            end
        end
    end

    task automatic drive(input logic [7:0] tag, input logic [1:0] n,
                         input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d);
        in_valid = 1'b1;
        in_tag   = tag;
        in_nsrc  = n;
        in_src0  = s0;
        in_src1  = s1;
        in_src2  = s2;
        in_dst   = d;
    endtask

    task automatic settle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (m_busy || busy); i++) begin
            @(posedge clk);
            #1;
        end
        chk("settle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int e0;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_tag    = '0;
        in_nsrc   = '0;
        in_src0   = '0;
        in_src1   = '0;
        in_src2   = '0;
        in_dst    = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1;

        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_addr", 64'(rf_read_addr), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_op0", out_op0, 64'd0);
        chk("rst_op2", out_op2, 64'd0);
        @(posedge clk);
        #1;

        // Three reads in order 5,6,7.
        settle();
        rf[5] = 64'h11;
        rf[6] = 64'h22;
        rf[7] = 64'h33;
        drive(8'hA1, 2'd3, 5'd5, 5'd6, 5'd7, 5'd9);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t1_addr0", 64'(rf_read_addr), 64'd5);
        chk("t1_v0", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_addr1", 64'(rf_read_addr), 64'd6);
        @(negedge clk);
        chk("t1_addr2", 64'(rf_read_addr), 64'd7);
        chk("t1_v2", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_op0", out_op0, 64'h11);
        chk("t1_op1", out_op1, 64'h22);
        chk("t1_op2", out_op2, 64'h33);
        chk("t1_tag", 64'(out_tag), 64'hA1);
        chk("t1_dst", 64'(out_dst), 64'd9);
        @(posedge clk);
        #1;

        // No sources: valid the cycle after accept.
        settle();
        drive(8'h05, 2'd0, 5'd1, 5'd2, 5'd3, 5'd3);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_addr", 64'(rf_read_addr), 64'd0);
        chk("t2_tag", 64'(out_tag), 64'h05);
        chk("t2_op0", out_op0, 64'd0);
        chk("t2_op1", out_op1, 64'd0);
        @(posedge clk);
        #1;

        // Backpressure, then back-to-back accept on release.
        settle();
        rf[3] = 64'h333;
        rf[4] = 64'h444;
        out_ready = 1'b0;
        drive(8'h33, 2'd2, 5'd3, 5'd4, 5'd0, 5'd12);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t3_addr0", 64'(rf_read_addr), 64'd3);
        @(negedge clk);
        chk("t3_addr1", 64'(rf_read_addr), 64'd4);
        @(posedge clk);
        #1;
        drive(8'h44, 2'd1, 5'd5, 5'd0, 5'd0, 5'd13);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_v", 64'(out_valid), 64'd1);
            chk("t3_hold_rdy", 64'(in_ready), 64'd0);
            chk("t3_hold_op0", out_op0, 64'h333);
            chk("t3_hold_op1", out_op1, 64'h444);
            chk("t3_hold_tag", 64'(out_tag), 64'h33);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("t3_rel_rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t3_b2b_v", 64'(out_valid), 64'd0);
        chk("t3_b2b_addr", 64'(rf_read_addr), 64'd5);
        @(negedge clk);
        chk("t3_b2b_valid", 64'(out_valid), 64'd1);
        chk("t3_b2b_op0", out_op0, 64'h11);
        chk("t3_b2b_op1", out_op1, 64'd0);
        chk("t3_b2b_tag", 64'(out_tag), 64'h44);
        chk("t3_b2b_dst", 64'(out_dst), 64'd13);
        @(posedge clk);
        #1;

        // Register write lands during the read cycle.
        settle();
        rf[8] = 64'h1234;
        drive(8'h48, 2'd1, 5'd8, 5'd0, 5'd0, 5'd2);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rf[8] = 64'hDEAD;
        chk("t4_addr", 64'(rf_read_addr), 64'd8);
        @(negedge clk);
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk("t4_op0", out_op0, 64'hDEAD);
        @(posedge clk);
        #1;

        // Reset during a read aborts the instruction.
        settle();
        e0 = d_emit;
        drive(8'h55, 2'd3, 5'd5, 5'd6, 5'd7, 5'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_ready", 64'(in_ready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_addr", 64'(rf_read_addr), 64'd0);
        chk("t5_op0", out_op0, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("t5_noemit", 64'(d_emit), 64'(e0));

        // Sources addressing r0.
        settle();
        rf[0] = '0;
        rf[4] = 64'h44;
        drive(8'h66, 2'd3, 5'd0, 5'd4, 5'd0, 5'd7);
        @(posedge clk);
        #1 in_valid = 1'b0;
`ifdef GPU_OPC_SKIP_R0_EN
        @(negedge clk);
        chk("t6_addr", 64'(rf_read_addr), 64'd4);
        chk("t6_v0", 64'(out_valid), 64'd0);
`else
        @(negedge clk);
        chk("t6_addr0", 64'(rf_read_addr), 64'd0);
        @(negedge clk);
        chk("t6_addr1", 64'(rf_read_addr), 64'd4);
        @(negedge clk);
        chk("t6_addr2", 64'(rf_read_addr), 64'd0);
        chk("t6_v2", 64'(out_valid), 64'd0);
`endif
        @(negedge clk);
        chk("t6_valid", 64'(out_valid), 64'd1);
        chk("t6_op0", out_op0, 64'd0);
        chk("t6_op1", out_op1, 64'h44);
        chk("t6_op2", out_op2, 64'd0);
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_tag    = 8'($urandom);
            in_nsrc   = 2'($urandom);
            in_src0   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            in_src1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            in_src2   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            in_dst    = 5'($urandom);
            reset     = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            if ($urandom_range(0, 1) == 1)
                rf[5'($urandom)] = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        settle();
        chk("emit_count", 64'(d_emit), 64'(m_emit));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
